// File: rtl/cfi_log_queue_if.sv
// Handshake bundle between the commit stage, the CFI log queue and the CFI checker.
// Per-port fields are packed arrays indexed by commit port.
interface cfi_log_queue_if #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned VLEN     = 64,
    parameter int unsigned CNT_W    = 16
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                               flush_i;
    logic                               mode_i;
    logic [3:0]                         mask_i;
    logic [NR_PORTS-1:0]                in_valid_i;
    logic [NR_PORTS-1:0][3:0]           in_flags_i;
    logic [NR_PORTS-1:0][VLEN-1:0]      in_pc_i;
    logic [NR_PORTS-1:0][VLEN-1:0]      in_npc_i;
    logic [NR_PORTS-1:0][VLEN-1:0]      in_target_i;
    logic                               in_ready_o;
    logic                               out_valid_o;
    logic                               out_ready_i;
    logic [3:0]                         out_flags_o;
    logic [VLEN-1:0]                    out_pc_o;
    logic [VLEN-1:0]                    out_npc_o;
    logic [VLEN-1:0]                    out_target_o;
    logic                               overflow_o;
    logic [CNT_W-1:0]                   drop_cnt_o;
    logic [CW-1:0]                      count_o;

    // Producer/consumer side (commit stage + checker).
    modport master (
        output flush_i, mode_i, mask_i, in_valid_i, in_flags_i, in_pc_i, in_npc_i,
               in_target_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_flags_o, out_pc_o, out_npc_o, out_target_o,
               overflow_o, drop_cnt_o, count_o
    );

    // Queue side.
    modport slave (
        input  flush_i, mode_i, mask_i, in_valid_i, in_flags_i, in_pc_i, in_npc_i,
               in_target_i, out_ready_i,
        output in_ready_o, out_valid_o, out_flags_o, out_pc_o, out_npc_o, out_target_o,
               overflow_o, drop_cnt_o, count_o
    );
endinterface

// File: rtl/cfi_log_queue.sv
// Multi-port control-flow log capture buffer.
// Up to NR_PORTS records per cycle are class-filtered and written in port order
// into a DEPTH-entry circular buffer; one record per cycle drains to the checker.
// When full, mode_i selects drop-and-count (0) or backpressure (1).
module cfi_log_queue #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned VLEN     = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    cfi_log_queue_if.slave q
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    // Masking keeps pointer wrap correct even for a single-entry buffer.
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [3:0]      flags;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] npc;
        logic [VLEN-1:0] target;
    } rec_t;

    rec_t                           mem [DEPTH];
    logic [PTR_W-1:0]               rd_ptr, wr_ptr;
    logic [CW-1:0]                  count, free;
    logic [NR_PORTS-1:0]            qual, acc;
    logic [NR_PORTS-1:0][PTR_W-1:0] slot;
    logic [CW-1:0]                  n_acc, n_drop;
    logic                           ready, pop;
    logic                           overflow;
    logic [CNT_W-1:0]               drop_cnt;
    logic [CNT_W:0]                 drop_sum;
    rec_t                           head;

    // A record is interesting only if one of its class flags is enabled.
    for (genvar p = 0; p < NR_PORTS; p++) begin : g_qual
        assign qual[p] = q.in_valid_i[p] && |(q.in_flags_i[p] & q.mask_i);
    end

    // Space is judged on the registered count: a same-cycle pop never frees a slot.
    assign free  = CW'(DEPTH) - count;
    assign ready = q.mode_i ? (free >= CW'(NR_PORTS)) : 1'b1;
    assign pop   = (count != '0) && q.out_ready_i;

    // Assign consecutive slots to qualifying ports in ascending order; overflow is dropped.
    always_comb begin
        n_acc  = '0;
        n_drop = '0;
        acc    = '0;
        slot   = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            slot[p] = (wr_ptr + PTR_W'(n_acc)) & PTR_MASK;
            if (qual[p]) begin
                if (q.mode_i ? ready : (n_acc < free)) begin
                    acc[p] = 1'b1;
                    n_acc  = n_acc + CW'(1);
                end else if (!q.mode_i) begin
                    n_drop = n_drop + CW'(1);
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

    // Pointers, occupancy and drop statistics; flush clears the buffer but keeps statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (q.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= (wr_ptr + PTR_W'(n_acc)) & PTR_MASK;
            if (pop) rd_ptr <= (rd_ptr + PTR_W'(1)) & PTR_MASK;
            count <= count + n_acc - CW'(pop);
            if (n_drop != '0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    // Record storage; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !q.flush_i) begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (acc[p]) begin
                    mem[slot[p]].flags  <= q.in_flags_i[p];
                    mem[slot[p]].pc     <= q.in_pc_i[p];
                    mem[slot[p]].npc    <= q.in_npc_i[p];
                    mem[slot[p]].target <= q.in_target_i[p];
                end
            end
        end
    end

    assign head           = mem[rd_ptr];
    assign q.in_ready_o   = ready;
    assign q.out_valid_o  = (count != '0);
    assign q.out_flags_o  = head.flags;
    assign q.out_pc_o     = head.pc;
    assign q.out_npc_o    = head.npc;
    assign q.out_target_o = head.target;
    assign q.overflow_o   = overflow;
    assign q.drop_cnt_o   = drop_cnt;
    assign q.count_o      = count;
endmodule
